// File: rtl/puf_uart_host_if.sv
// Challenge/response bus between host logic, the PUF UART host and its uart_tx/uart_rx pair.
// master: host/bench side that issues challenges and models the UART.
// slave:  puf_uart_host itself.
interface puf_uart_host_if #(
  parameter int W = 64
);
  logic [W-1:0] chal;
  logic         chal_valid;
  logic         chal_ready;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic         tx_active;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic [W-1:0] resp;
  logic         resp_valid;
  logic         timeout;
  logic         busy;

  modport master (
    output chal, chal_valid, tx_active, rx_valid, rx_byte,
    input  chal_ready, tx_valid, tx_byte, resp, resp_valid, timeout, busy
  );

  modport slave (
    input  chal, chal_valid, tx_active, rx_valid, rx_byte,
    output chal_ready, tx_valid, tx_byte, resp, resp_valid, timeout, busy
  );
endinterface

// File: rtl/puf_uart_host.sv
// Host-side initiator for the UART PUF link: sends a challenge word MSB byte first
// over uart_tx, then gathers NBYTES response bytes from uart_rx into a word whose
// first received byte sits in the least significant position.
module puf_uart_host #(
  parameter int              NBYTES  = 8,
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  puf_uart_host_if.slave  bus
);

  localparam int              W    = 8 * NBYTES;
  localparam int              CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);
  localparam logic [TO_W-1:0] TERM = TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_END,
    RX,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    shift_sr;
  logic [W-1:0]    resp_sr;
  logic [CW-1:0]   cnt;
  logic [TO_W-1:0] timer;
  logic            prev_tx_active;
  logic            prev_rx_valid;
  logic            tx_rise;
  logic            tx_fall;
  logic            rx_rise;

  assign tx_rise = bus.tx_active & ~prev_tx_active;
  assign tx_fall = ~bus.tx_active & prev_tx_active;
  assign rx_rise = bus.rx_valid & ~prev_rx_valid;

  // Remember last cycle's UART levels so edges, not levels, advance the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_tx_active <= 1'b0;
      prev_rx_valid  <= 1'b0;
    end else begin
      prev_tx_active <= bus.tx_active;
      prev_rx_valid  <= bus.rx_valid;
    end
  end

  // Transfer sequencer; the timeout check comes first so it beats a same-cycle edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shift_sr       <= '0;
      resp_sr        <= '0;
      cnt            <= '0;
      timer          <= '0;
      bus.chal_ready <= 1'b1;
      bus.tx_valid   <= 1'b0;
      bus.tx_byte    <= '0;
      bus.resp       <= '0;
      bus.resp_valid <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.timeout    <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (bus.chal_valid && bus.chal_ready) begin
            shift_sr       <= bus.chal;
            cnt            <= '0;
            bus.tx_valid   <= 1'b1;
            bus.tx_byte    <= bus.chal[W-1 -: 8];
            bus.chal_ready <= 1'b0;
            bus.busy       <= 1'b1;
            state          <= TX_START;
          end
        end
        TX_START: begin
          if (timer == TERM) begin
            timer          <= TIMEOUT;
            bus.timeout    <= 1'b1;
            bus.tx_valid   <= 1'b0;
            cnt            <= '0;
            bus.chal_ready <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else if (tx_rise) begin
            timer <= '0;
            state <= TX_END;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        TX_END: begin
          if (tx_fall) begin
            shift_sr <= shift_sr << 8;
            if (cnt == LAST) begin
              bus.tx_valid <= 1'b0;
              cnt          <= '0;
              state        <= RX;
            end else begin
              cnt         <= cnt + 1'b1;
              bus.tx_byte <= shift_sr[W-9 -: 8];
              state       <= TX_START;
            end
          end
        end
        RX: begin
          if (timer == TERM) begin
            timer          <= TIMEOUT;
            bus.timeout    <= 1'b1;
            cnt            <= '0;
            bus.chal_ready <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else if (rx_rise) begin
            resp_sr <= {bus.rx_byte, resp_sr[W-1:8]};
            timer   <= '0;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          bus.resp       <= resp_sr;
          bus.resp_valid <= 1'b1;
          bus.chal_ready <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
